// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes, FSM states,
// access sizes and the alignment-mask helper.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} lsu_state_e;

  // Encoding matches funct3[1:0] so the size decodes by a plain cast.
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} lsu_size_e;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: return 3'b000;
      SZ_HALF: return 3'b001;
      SZ_WORD: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling on one doubleword: extract+extend for loads,
// replace-one-lane merge for sub-doubleword stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [63:0] i_dword,
  input  logic [2:0]  i_offset,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load_data,
  output logic [63:0] o_merge_data
);

  logic [5:0]  w_shamt;
  logic [63:0] w_shifted;
  logic [63:0] w_base_mask;
  logic [63:0] w_lane_mask;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_dword >> w_shamt;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_load_data = i_dword;
    w_base_mask = '1;
    case (i_size)
      SZ_BYTE: begin
        o_load_data = {{56{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        w_base_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_HALF: begin
        o_load_data = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        w_base_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_WORD: begin
        o_load_data = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
        w_base_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        o_load_data = i_dword;
        w_base_mask = '1;
      end
    endcase
  end

  assign w_lane_mask  = w_base_mask << w_shamt;
  assign o_merge_data = (i_dword & ~w_lane_mask) | ((i_wdata & w_base_mask) << w_shamt);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, doubleword-only memory port,
// read-extract for loads and read-modify-write for narrow stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  output logic [63:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [63:0]           write_data,
  input  logic [63:0]           read_data
);

  lsu_state_e            r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_wdata, r_old, r_rdata;
  lsu_size_e             r_size;
  logic                  r_unsigned, r_is_load, r_error;

  lsu_size_e   w_req_size;
  logic        w_accept, w_misaligned, w_dec_error;
  logic [2:0]  w_offset;
  logic [63:0] w_align_in, w_load_data, w_merge_data;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_req_size   = lsu_size_e'(req_funct3[1:0]);
  assign w_misaligned = CHECK_ALIGN && ((req_addr[2:0] & size_mask(w_req_size)) != 3'b000);
  assign w_dec_error  = (req_load == req_store) ||
                        (req_load && (req_funct3 == 3'b111)) ||
                        (req_store && req_funct3[2]) ||
                        w_misaligned;

  // With alignment checking off, the low bits below the access size are dropped.
  assign w_offset   = r_addr[2:0] & ~size_mask(r_size);
  assign w_align_in = (r_state == S_READ) ? read_data : r_old;

  lsu_lane_align u_lane_align (
    .i_dword      (w_align_in),
    .i_offset     (w_offset),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_old      <= '0;
      r_rdata    <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_is_load  <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= w_req_size;
        r_unsigned <= req_funct3[2];
        r_is_load  <= req_load & ~req_store;
        r_error    <= w_dec_error;
        r_rdata    <= '0;
      end
      if (r_state == S_READ) begin
        if (r_is_load) r_rdata <= w_load_data;
        else           r_old   <= read_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_error   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    address      = '0;
    write_data   = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_dec_error)                w_next_state = S_RESP;
          else if (req_load)              w_next_state = S_READ;
          else if (w_req_size == SZ_DOUBLE) w_next_state = S_WRITE;
          else                            w_next_state = S_READ;
        end
      end
      S_READ: begin
        mem_read     = reset_n;
        address      = {r_addr[ADDR_WIDTH-1:3], 3'b000};
        w_next_state = r_is_load ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        mem_write    = reset_n;
        address      = {r_addr[ADDR_WIDTH-1:3], 3'b000};
        write_data   = (r_size == SZ_DOUBLE) ? r_wdata : w_merge_data;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = r_rdata;
        resp_error   = r_error;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: behavioural doubleword memory, response
// scoreboard queue, latency and memory-traffic checks per transaction.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int AW = 64;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic          req_load = 1'b0, req_store = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          resp_valid, resp_error;
  logic [63:0]   resp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] address;
  logic [63:0]   write_data, read_data;

  logic [63:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;
  int          n_reads = 0, n_writes = 0;
  logic [63:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

  int   n_checks = 0, n_fail = 0;
  int   rd0 = 0, wr0 = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  assign read_data = mem[address[8:3]];

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_read) begin
      n_reads      <= n_reads + 1;
      last_rd_addr <= address;
    end
    if (mem_write) begin
      mem[address[8:3]] <= write_data;
      n_writes          <= n_writes + 1;
      last_wr_addr      <= address;
      last_wr_data      <= write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [63:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic push_exp(input logic [63:0] rdata, input logic err, input int lat,
                          input int reads, input int writes);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.reads = reads; e.writes = writes;
    sb.push_back(e);
  endtask

  task automatic wait_accept(input string tag);
    int c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clock);
      c++;
    end
    if (!req_ready) check({tag, " accept_timeout"}, req_ready, 1);
    @(posedge clock); #1;
    rd0 = n_reads;
    wr0 = n_writes;
  endtask

  task automatic wait_resp(input string tag);
    exp_t e;
    int   lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " resp_valid"}, resp_valid, 1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, resp_rdata, e.rdata);
      check({tag, " error"}, resp_error, e.err);
      check({tag, " latency"}, lat, e.lat);
      check({tag, " mem_reads"}, n_reads - rd0, e.reads);
      check({tag, " mem_writes"}, n_writes - wr0, e.writes);
    end
  endtask

  task automatic do_req(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdata, input logic err, input int lat,
                        input int reads, input int writes);
    push_exp(rdata, err, lat, reads, writes);
    drive(ld, st, f3, a, wd);
    wait_accept(tag);
    req_valid = 1'b0;
    wait_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    preload(6'd0, 64'h1122_3344_5566_7788);
    preload(6'd1, 64'h0);
    preload(6'd2, 64'h0);
    preload(6'd3, 64'hCAFE_BABE_1234_5678);
    preload(6'd63, 64'h0123_4567_89AB_CDEF);
    @(negedge clock);
    check("rst req_ready", req_ready, 1);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_error", resp_error, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst address", address, 0);
    check("rst write_data", write_data, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Loads from word0 = 0x1122334455667788
    do_req("LB 0x0",  1, 0, F3_LB,  64'h0, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, 1, 0);
    do_req("LBU 0x0", 1, 0, F3_LBU, 64'h0, 0, 64'h88, 0, 2, 1, 0);
    do_req("LB 0x7",  1, 0, F3_LB,  64'h7, 0, 64'h11, 0, 2, 1, 0);
    do_req("LH 0x6",  1, 0, F3_LH,  64'h6, 0, 64'h1122, 0, 2, 1, 0);
    do_req("LW 0x4",  1, 0, F3_LW,  64'h4, 0, 64'h1122_3344, 0, 2, 1, 0);
    do_req("LD 0x0",  1, 0, F3_LD,  64'h0, 0, 64'h1122_3344_5566_7788, 0, 2, 1, 0);
    do_req("LWU 0x0", 1, 0, F3_LWU, 64'h0, 0, 64'h5566_7788, 0, 2, 1, 0);

    // Narrow store: only the low byte of wdata lands in lane 2 of word1
    do_req("SB 0xA", 0, 1, F3_SB, 64'hA, 64'h55AB, 64'h0, 0, 3, 1, 1);
    check("SB wr_addr", last_wr_addr, 64'h8);
    check("SB wr_data", last_wr_data, 64'h0000_0000_00AB_0000);

    // Full doubleword store needs no read
    do_req("SD 0x10", 0, 1, F3_SD, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 2, 0, 1);
    check("SD wr_addr", last_wr_addr, 64'h10);
    do_req("LD 0x10",  1, 0, F3_LD,  64'h10, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 2, 1, 0);
    do_req("LW 0x10",  1, 0, F3_LW,  64'h10, 0, 64'hFFFF_FFFF_CAFE_F00D, 0, 2, 1, 0);
    do_req("LWU 0x14", 1, 0, F3_LWU, 64'h14, 0, 64'hDEAD_BEEF, 0, 2, 1, 0);
    do_req("LH 0x12",  1, 0, F3_LH,  64'h12, 0, 64'hFFFF_FFFF_FFFF_CAFE, 0, 2, 1, 0);
    do_req("LHU 0x12", 1, 0, F3_LHU, 64'h12, 0, 64'hCAFE, 0, 2, 1, 0);

    // Errors: one cycle, no memory traffic
    do_req("err LH 0x3",  1, 0, F3_LH,  64'h3, 0, 64'h0, 1, 1, 0, 0);
    do_req("err SW 0x6",  0, 1, F3_SW,  64'h6, 64'h1, 64'h0, 1, 1, 0, 0);
    do_req("err load f3=111", 1, 0, 3'b111, 64'h0, 0, 64'h0, 1, 1, 0, 0);
    do_req("err store f3=100", 0, 1, 3'b100, 64'h0, 64'h1, 64'h0, 1, 1, 0, 0);
    do_req("err both ops", 1, 1, F3_LD, 64'h0, 0, 64'h0, 1, 1, 0, 0);
    do_req("err no op",    0, 0, F3_LD, 64'h0, 0, 64'h0, 1, 1, 0, 0);

    // Top of the address space passes through unchanged
    do_req("LD top", 1, 0, F3_LD, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0123_4567_89AB_CDEF, 0, 2, 1, 0);
    check("LD top rd_addr", last_rd_addr, 64'hFFFF_FFFF_FFFF_FFF8);

    // Reset asserted during the WRITE cycle of an SH
    drive(0, 1, F3_SH, 64'h18, 64'h9999);
    wait_accept("SH rst");
    req_valid = 1'b0;
    @(negedge clock);
    check("SH rst read_cycle", mem_read, 1);
    @(negedge clock);
    check("SH rst write_cycle", mem_write, 1);
    reset_n = 1'b0;
    #1;
    check("SH rst write_gated", mem_write, 0);
    @(negedge clock);
    reset_n = 1'b1;
    check("SH rst req_ready", req_ready, 1);
    check("SH rst resp_valid", resp_valid, 0);
    check("SH rst mem_writes", n_writes - wr0, 0);
    check("SH rst mem_unchanged", mem[3], 64'hCAFE_BABE_1234_5678);

    // Back-to-back SW then LW with req_valid held high
    push_exp(64'h0, 0, 3, 1, 1);
    drive(0, 1, F3_SW, 64'h0, 64'h0102_0304);
    wait_accept("b2b SW");
    drive(1, 0, F3_LW, 64'h0, 64'h0);
    wait_resp("b2b SW");
    check("b2b SW wr_data", last_wr_data, 64'h1122_3344_0102_0304);
    check("b2b busy req_ready", req_ready, 0);
    @(negedge clock);
    check("b2b idle req_ready", req_ready, 1);
    push_exp(64'h0102_0304, 0, 2, 1, 0);
    wait_accept("b2b LW");
    req_valid = 1'b0;
    wait_resp("b2b LW");
    do_req("LD 0x0 after SW", 1, 0, F3_LD, 64'h0, 0, 64'h1122_3344_0102_0304, 0, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
